// File: rtl/sh_right_pkg.sv
// -----------------------------------------------------------------------------
// sh_right_pkg
// Shared types and constants for the multi-cycle right shifter.
//   shr_op_t    : operation code (SRL, SRA, ROR, reserved)
//   shr_state_t : controller state encoding
//   W_DEF       : default operand width
// Optional feature macro: SH_RIGHT_ROTATE_EN (see sh_right_step).
// -----------------------------------------------------------------------------
package sh_right_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_ROR = 2'b10,
        OP_RSV = 2'b11
    } shr_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shr_state_t;

endpackage : sh_right_pkg

// File: rtl/sh_right_step.sv
// -----------------------------------------------------------------------------
// sh_right_step
// Combinational one-bit right step of the working register.
//   sreg_i : current working value (W bits)
//   op_i   : operation (SRL / SRA / ROR / reserved)
//   nxt_o  : working value after one right step
// Fill bit entering the MSB:
//   SRL, reserved : 0
//   SRA           : sreg_i[W-1] (sign replicates, so it stays the captured sign)
//   ROR           : sreg_i[0] when SH_RIGHT_ROTATE_EN is defined, otherwise 0
// Macro: SH_RIGHT_ROTATE_EN enables the rotate path; without it no rotate
// logic is built and OP_ROR behaves exactly like SRL.
// -----------------------------------------------------------------------------
module sh_right_step
    import sh_right_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] sreg_i,
    input  shr_op_t      op_i,
    output logic [W-1:0] nxt_o
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        case (op_i)
            OP_SRA:  fill = sreg_i[W-1];
`ifdef SH_RIGHT_ROTATE_EN
            OP_ROR:  fill = sreg_i[0];
`endif
            default: fill = 1'b0;
        endcase
        nxt_o        = sreg_i >> 1;
        nxt_o[W-1]   = fill;
    end

endmodule : sh_right_step

// File: rtl/sh_right_seq.sv
// -----------------------------------------------------------------------------
// sh_right_seq
// Multi-cycle right shifter: shifts a W-bit operand right by 0..W-1 bits,
// one bit per clock, with a start/done handshake.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only while idle (busy==0)
//   x         : operand, captured on accept
//   shamt     : shift amount, captured on accept
//   op        : 00 SRL, 01 SRA, 10 ROR (macro only, else SRL), 11 acts as SRL
//   busy      : high while a request is in flight (SHIFT or DONE)
//   done      : one-cycle pulse, s valid in that cycle
//   s         : result, held from done until the next accepted start
//   state_dbg : current controller state, for observation only
// Handshake: a request is accepted on a clock edge where start==1 and the
// unit is idle; starts seen while busy (including the DONE cycle) are dropped,
// never queued. done follows edge E(shamt+1) after the accepting edge E0.
// Macro: SH_RIGHT_ROTATE_EN enables rotate-right for op=10.
// -----------------------------------------------------------------------------
module sh_right_seq
    import sh_right_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [SHW-1:0] shamt,
    input  logic [1:0]     op,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   s,
    output shr_state_t     state_dbg
);

    shr_state_t     state_q, state_d;
    logic [W-1:0]   sreg_q,  sreg_d;
    logic [SHW-1:0] cnt_q,   cnt_d;
    shr_op_t        op_q,    op_d;
    logic [W-1:0]   s_q,     s_d;
    logic [W-1:0]   step_nxt;

    sh_right_step #(.W(W)) u_step (
        .sreg_i (sreg_q),
        .op_i   (op_q),
        .nxt_o  (step_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SRL;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        s_d     = s_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d  = x;
                    cnt_d   = shamt;
                    op_d    = shr_op_t'(op);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d = step_nxt;
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    // Only the finished value ever reaches s.
                    s_d     = sreg_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // done is exactly the one DONE cycle, so it is a pure state decode.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign s         = s_q;
    assign state_dbg = state_q;

endmodule : sh_right_seq

// File: tb/tb_sh_right_seq.sv
// -----------------------------------------------------------------------------
// tb_sh_right_seq
// Directed testbench for sh_right_seq with hand-computed expected values.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_sh_right_seq;
    import sh_right_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] s;
    shr_state_t  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    sh_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .shamt     (shamt),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion, checking busy during the
    // run, the done latency, the result and the return to idle.
    task automatic run_op(input string tag, input logic [31:0] xv, input logic [4:0] sv,
                          input logic [1:0] ov, input logic [31:0] exp);
        int cyc;
        int busy_low;
        @(negedge clk);
        start = 1'b1; x = xv; shamt = sv; op = ov;
        @(posedge clk);                 // E0: accept
        #1;
        start = 1'b0;
        x = $urandom; shamt = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
        busy_low = 0;
        if (!busy) busy_low++;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (!busy) busy_low++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(sv) + 32'd1);
        chk({tag, "_busy_run"}, 32'(busy_low), 32'd0);
        chk({tag, "_s"}, s, exp);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_s_hold"}, s, exp);
    endtask

    initial begin
        int ndone;
        int dk;
        logic [31:0] sres;

        rst_n = 1'b0; start = 1'b0; x = '0; shamt = '0; op = '0;
        #1;
        chk("reset_outs", {30'd0, busy, done}, 32'd0);
        chk("reset_s", s, 32'd0);
        chk("reset_state", 32'(state_dbg), 32'(S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: SRL full-width shift, longest latency
        run_op("srl31", 32'h8000_0000, 5'd31, 2'b00, 32'h0000_0001);
        // 2: SRA negative and positive operands
        run_op("sra_neg", 32'h8000_0000, 5'd4, 2'b01, 32'hF800_0000);
        run_op("sra_pos", 32'h7000_0000, 5'd4, 2'b01, 32'h0700_0000);
        run_op("sra8", 32'hDEAD_BEEF, 5'd8, 2'b01, 32'hFFDE_ADBE);
        // 3: zero shift passes the operand through
        run_op("sh0", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF);
        // reserved op behaves as SRL
        run_op("rsv", 32'hDEAD_BEEF, 5'd8, 2'b11, 32'h00DE_ADBE);

        // 4: starts while busy (SHIFT and DONE) are dropped
        @(negedge clk);
        start = 1'b1; x = 32'h0000_00F0; shamt = 5'd4; op = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; dk = 0; sres = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k <= 6); x = 32'h0000_0001; shamt = 5'd0; op = 2'b00;
            @(posedge clk);
            #1;
            if (done) begin
                ndone++; dk = k; sres = s;
            end
        end
        start = 1'b0;
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_edge", 32'(dk), 32'd5);
        chk("busy_start_s", sres, 32'h0000_000F);
        chk("busy_start_idle", {31'd0, busy}, 32'd0);
        chk("busy_start_hold", s, 32'h0000_000F);

        // 5: reset in the middle of a shift
        @(negedge clk);
        start = 1'b1; x = 32'hFFFF_0000; shamt = 5'd20; op = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_s", s, 32'h0000_000F);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {30'd0, busy, done}, 32'd0);
        chk("rst_mid_s", s, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        run_op("after_rst", 32'h1234_5678, 5'd4, 2'b00, 32'h0123_4567);

        // 6: op=10
`ifdef SH_RIGHT_ROTATE_EN
        run_op("ror1", 32'h0000_0001, 5'd1, 2'b10, 32'h8000_0000);
        run_op("ror8", 32'hDEAD_BEEF, 5'd8, 2'b10, 32'hEFDE_ADBE);
`else
        run_op("ror1_as_srl", 32'h0000_0001, 5'd1, 2'b10, 32'h0000_0000);
        run_op("ror8_as_srl", 32'hDEAD_BEEF, 5'd8, 2'b10, 32'h00DE_ADBE);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sh_right_seq
